// File: rtl/simon_seq_if.sv
// Tick/start/random/button inputs and game-state outputs of the simon_seq sequencer.
// The master side drives the player inputs; the slave side is the sequencer.
interface simon_seq_if #(
    parameter int CW = 2,
    parameter int LW = 6
);
    logic          tick;
    logic          start;
    logic [CW-1:0] rnd;
    logic [CW-1:0] btn_num;
    logic          btn_pressed;
    logic          simon_turn;
    logic [CW-1:0] simon_num;
    logic          simon_pressed;
    logic          game_over;
    logic          win;
    logic [LW-1:0] level;

    modport master (
        output tick, start, rnd, btn_num, btn_pressed,
        input  simon_turn, simon_num, simon_pressed, game_over, win, level
    );
    modport slave (
        input  tick, start, rnd, btn_num, btn_pressed,
        output simon_turn, simon_num, simon_pressed, game_over, win, level
    );
endinterface

// File: rtl/simon_seq.sv
// Simon memory-game sequencer: grows a random channel sequence, plays it back, checks the player.
// Define SIMON_TIMEOUT_EN to end the game when no press arrives within TIMEOUT_TICKS ticks.
module simon_seq #(
    parameter int NUM_CH        = 4,
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 25,
    parameter int GAP_TICKS     = 10,
    parameter int TIMEOUT_TICKS = 250,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic      clk,
    input  logic      reset,
    simon_seq_if.slave bus
);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MD   = 1 << AW;
    localparam int TM1  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TMAX = (TM1 > TIMEOUT_TICKS) ? TM1 : TIMEOUT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_APPEND, S_GAP, S_PLAY_ON, S_WAIT_PRESS, S_WAIT_RELEASE, S_OVER, S_WIN
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d, idx_q, idx_d, idx_inc;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          btn_prev_q;
    logic          rise, mem_we;
    logic [CW-1:0] rnd_mod, exp_num;
    logic [CW-1:0] mem_q [MD];

    logic          simon_turn_q, simon_turn_d;
    logic [CW-1:0] simon_num_q, simon_num_d;
    logic          simon_pressed_q, simon_pressed_d;
    logic          game_over_q, game_over_d;
    logic          win_q, win_d;

    assign idx_inc = idx_q + LW'(1);
    assign rise    = bus.btn_pressed & ~btn_prev_q;
    assign exp_num = mem_q[idx_q[AW-1:0]];
    assign rnd_mod = CW'(32'(bus.rnd) % NUM_CH);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        cnt_d   = bus.tick ? cnt_q + TW'(1) : cnt_q;
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (bus.start) begin
                    level_d = '0;
                    state_d = S_APPEND;
                end
            end
            S_APPEND: begin
                mem_we  = 1'b1;
                level_d = level_q + LW'(1);
                idx_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (bus.tick && cnt_q == TW'(GAP_TICKS - 1)) state_d = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (bus.tick && cnt_q == TW'(ON_TICKS - 1)) begin
                    if (idx_inc < level_q) begin
                        idx_d   = idx_inc;
                        state_d = S_GAP;
                    end else begin
                        idx_d   = '0;
                        state_d = S_WAIT_PRESS;
                    end
                end
            end
            S_WAIT_PRESS: begin
                if (rise) state_d = (bus.btn_num == exp_num) ? S_WAIT_RELEASE : S_OVER;
`ifdef SIMON_TIMEOUT_EN
                else if (bus.tick && cnt_q == TW'(TIMEOUT_TICKS - 1)) state_d = S_OVER;
`endif
            end
            S_WAIT_RELEASE: begin
                if (!bus.btn_pressed) begin
                    if (idx_inc < level_q) begin
                        idx_d   = idx_inc;
                        state_d = S_WAIT_PRESS;
                    end else if (level_q == LW'(MAX_LEN)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_APPEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A tick on the transition edge belongs to the state being left.
        if (state_d != state_q) cnt_d = '0;

        simon_turn_d    = (state_d == S_APPEND) || (state_d == S_GAP) || (state_d == S_PLAY_ON);
        simon_pressed_d = (state_d == S_PLAY_ON);
        simon_num_d     = (state_d == S_PLAY_ON) ? mem_q[idx_d[AW-1:0]] : simon_num_q;
        game_over_d     = (state_d == S_OVER);
        win_d           = (state_d == S_WIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            level_q         <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            btn_prev_q      <= 1'b0;
            simon_turn_q    <= 1'b0;
            simon_num_q     <= '0;
            simon_pressed_q <= 1'b0;
            game_over_q     <= 1'b0;
            win_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            btn_prev_q      <= bus.btn_pressed;
            simon_turn_q    <= simon_turn_d;
            simon_num_q     <= simon_num_d;
            simon_pressed_q <= simon_pressed_d;
            game_over_q     <= game_over_d;
            win_q           <= win_d;
        end
    end

    // Sequence storage survives reset; a new game overwrites it from index 0.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[level_q[AW-1:0]] <= rnd_mod;
    end

    assign bus.simon_turn    = simon_turn_q;
    assign bus.simon_num     = simon_num_q;
    assign bus.simon_pressed = simon_pressed_q;
    assign bus.game_over     = game_over_q;
    assign bus.win           = win_q;
    assign bus.level         = level_q;
endmodule

// File: tb/tb_simon_seq.sv
// Randomized self-checking bench for simon_seq: two instances (NUM_CH=4/MAX_LEN=32 and
// NUM_CH=6/MAX_LEN=2) share stimulus; a sequence queue model predicts playback and results.
module tb_simon_seq;
    localparam int ON_T  = 25;
    localparam int GAP_T = 10;
    localparam int TO_T  = 250;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, start, btn_p;
    logic [2:0] rnd, btn;
    bit         sel;
    int         n_vec = 0, n_err = 0;
    int         exp_q[$];
    int         o_turn, o_num, o_pr, o_over, o_win, o_lvl;

    always #5 clk = ~clk;

    simon_seq_if #(.CW(2), .LW(6)) bus0 ();
    simon_seq_if #(.CW(3), .LW(2)) bus1 ();

    assign bus0.tick = tick;  assign bus0.start = start;  assign bus0.btn_pressed = btn_p;
    assign bus0.rnd  = rnd[1:0];  assign bus0.btn_num = btn[1:0];
    assign bus1.tick = tick;  assign bus1.start = start;  assign bus1.btn_pressed = btn_p;
    assign bus1.rnd  = rnd;       assign bus1.btn_num = btn;

    simon_seq #(.NUM_CH(4), .MAX_LEN(32), .ON_TICKS(ON_T), .GAP_TICKS(GAP_T), .TIMEOUT_TICKS(TO_T))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    simon_seq #(.NUM_CH(6), .MAX_LEN(2), .ON_TICKS(ON_T), .GAP_TICKS(GAP_T), .TIMEOUT_TICKS(TO_T))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always_comb begin
        if (sel) begin
            o_turn = int'(bus1.simon_turn);  o_num = int'(bus1.simon_num);
            o_pr   = int'(bus1.simon_pressed); o_over = int'(bus1.game_over);
            o_win  = int'(bus1.win);         o_lvl = int'(bus1.level);
        end else begin
            o_turn = int'(bus0.simon_turn);  o_num = int'(bus0.simon_num);
            o_pr   = int'(bus0.simon_pressed); o_over = int'(bus0.game_over);
            o_win  = int'(bus0.win);         o_lvl = int'(bus0.level);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rtick();
        return $urandom_range(0, 3) != 0;
    endfunction

    function automatic int red(input logic [2:0] r);
        logic [1:0] lo;
        lo = r[1:0];
        return sel ? int'(r) % 6 : int'(lo) % 4;
    endfunction

    function automatic int nch();
        return sel ? 6 : 4;
    endfunction

    // Called on the APPEND cycle; follows the whole playback of n tones.
    task automatic play_check(input int n);
        int tones, on_t, gap_t, guard;
        bit prev_p, skip;
        tones = 0; on_t = 0; gap_t = 0; guard = 0; prev_p = 0; skip = 1;
        while (guard < 8000) begin
            if (o_pr == 1 && !prev_p) begin
                chk("gap_ticks", gap_t, GAP_T);
                chk("tone", o_num, exp_q[tones]);
                on_t = 0;
            end
            if (o_pr == 0 && prev_p) begin
                chk("on_ticks", on_t, ON_T);
                tones++;
                gap_t = 0;
                if (tones == n) break;
            end
            prev_p = (o_pr == 1);
            tick = rtick();
            if (o_pr == 1) on_t += int'(tick);
            else if (o_turn == 1) begin
                if (skip) skip = 0;
                else gap_t += int'(tick);
            end
            guard++;
            cyc();
        end
        chk("tones_played", tones, n);
        chk("turn_after_play", o_turn, 0);
    endtask

    task automatic append_and_play(input bit hold_wrong);
        exp_q.push_back(red(rnd));
        if (hold_wrong) begin
            btn   = 3'((exp_q[0] + 1) % nch());
            btn_p = 1'b1;
        end
        play_check(exp_q.size());
        chk("level", o_lvl, exp_q.size());
    endtask

    task automatic start_game(input logic [2:0] r);
        rnd = r; start = 1'b1; tick = rtick();
        cyc();
        start = 1'b0;
        exp_q.delete();
        chk("over_clr", o_over, 0);
        chk("win_clr", o_win, 0);
        append_and_play(1'b0);
    endtask

    task automatic press(input int ch, input bit ok, input logic [2:0] r);
        repeat ($urandom_range(0, 4)) begin tick = rtick(); cyc(); end
        btn = 3'(ch); btn_p = 1'b1; tick = rtick();
        cyc();
        if (!ok) begin
            chk("over_next", o_over, 1);
            btn_p = 1'b0;
            return;
        end
        chk("no_over", o_over, 0);
        repeat ($urandom_range(0, 3)) begin tick = rtick(); cyc(); end
        btn_p = 1'b0; rnd = r; tick = rtick();
        cyc();
    endtask

    task automatic play_correct(input logic [2:0] r);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) press(exp_q[i], 1'b1, r);
    endtask

    initial begin
        int lvl, t;
        sel = 0; tick = 0; start = 0; btn_p = 0; rnd = '0; btn = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_turn", o_turn, 0); chk("rst_pressed", o_pr, 0); chk("rst_num", o_num, 0);
        chk("rst_over", o_over, 0); chk("rst_win", o_win, 0);   chk("rst_level", o_lvl, 0);
        reset = 1'b0;
        cyc();

        // First round plays tone 2, then rounds 2,1 and random growth.
        start_game(3'd2);
        play_correct(3'd1);
        append_and_play(1'b0);
        play_correct(3'($urandom));
        append_and_play(1'b0);
        for (int k = 0; k < 3; k++) begin
            play_correct(3'($urandom));
            append_and_play(1'b0);
        end

        // start is ignored while waiting for the player.
        lvl = o_lvl;
        start = 1'b1; cyc(); start = 1'b0; cyc();
        chk("start_ign_lvl", o_lvl, lvl);
        chk("start_ign_turn", o_turn, 0);

        // A button already held on entry to the press phase does not count.
        play_correct(3'($urandom));
        append_and_play(1'b1);
        repeat (20) begin tick = rtick(); cyc(); end
        chk("held_no_over", o_over, 0);
        btn_p = 1'b0; cyc();
        play_correct(3'($urandom));
        append_and_play(1'b0);

        // Wrong press ends the game; level holds in OVER.
        lvl = o_lvl;
        press((exp_q[0] + 1) % 4, 1'b0, 3'd0);
        repeat (3) cyc();
        chk("over_hold", o_over, 1);
        chk("over_level", o_lvl, lvl);
        chk("over_win", o_win, 0);

        start_game(3'd2);
        press(3, 1'b0, 3'd0);
        chk("over_lvl1", o_lvl, 1);
        start_game(3'($urandom));

`ifdef SIMON_TIMEOUT_EN
        t = 0;
        while (t < TO_T - 1) begin
            tick = rtick();
            if (tick) t++;
            cyc();
        end
        chk("to_before", o_over, 0);
        tick = 1'b1; cyc();
        chk("to_fire", o_over, 1);
`else
        t = 0;
        repeat (1000) begin tick = 1'b1; t++; cyc(); end
        chk("no_to_over", o_over, 0);
        chk("no_to_turn", o_turn, 0);
        play_correct(3'($urandom));
        append_and_play(1'b0);
`endif

        // Reset in the middle of a playback tone.
        reset = 1'b1; cyc(); reset = 1'b0;
        rnd = 3'($urandom); start = 1'b1; cyc(); start = 1'b0;
        t = 0;
        while (o_pr == 0 && t < 200) begin tick = 1'b1; t++; cyc(); end
        chk("reach_play", o_pr, 1);
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        chk("arst_pressed", o_pr, 0);
        chk("arst_turn", o_turn, 0);
        chk("arst_level", o_lvl, 0);
        cyc();
        reset = 1'b0;

        // MAX_LEN=2, NUM_CH=6 instance: modulo reduction and win.
        sel = 1;
        cyc();
        start_game(3'd7);
        play_correct(3'($urandom));
        append_and_play(1'b0);
        play_correct(3'd0);
        chk("win", o_win, 1);
        chk("win_level", o_lvl, 2);
        chk("win_over", o_over, 0);
        repeat (3) cyc();
        chk("win_hold", o_win, 1);
        start_game(3'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/simon_seq.md
SIMON_SEQ -- requirements
Module: simon_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of button/LED/tone channels (2..16).
REQ-002 Parameter MAX_LEN, default 32, maximum sequence length (1..256).
REQ-003 Parameter ON_TICKS, default 25, ticks a playback tone is held.
REQ-004 Parameter GAP_TICKS, default 10, silent ticks between playback tones and before each playback.
REQ-005 Parameter TIMEOUT_TICKS, default 250, ticks allowed per player press.
REQ-006 CW = max(1, clog2(NUM_CH)); LW = clog2(MAX_LEN+1).
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 tick  input  1  one-cycle timing strobe; all tick counters advance only when tick=1.
REQ-010 start  input  1  begin new game (sampled in IDLE, OVER, WIN).
REQ-011 rnd  input  CW  random channel source, sampled in APPEND.
REQ-012 btn_num  input  CW  channel of the player's pressed button.
REQ-013 btn_pressed  input  1  level, player button held.
REQ-014 simon_turn  output  1  high while the sequencer owns LEDs/speaker.
REQ-015 simon_num  output  CW  channel being played.
REQ-016 simon_pressed  output  1  high while a playback tone is on.
REQ-017 game_over  output  1  high in OVER.
REQ-018 win  output  1  high in WIN.
REQ-019 level  output  LW  current sequence length.

Function
REQ-020 States SHALL be IDLE, APPEND, GAP, PLAY_ON, WAIT_PRESS, WAIT_RELEASE, OVER, WIN.
REQ-021 IDLE: start=1 -> clear level to 0, go APPEND.
REQ-022 APPEND: rnd mod NUM_CH written to mem[level], level+=1, play index=0, go GAP; one clk cycle, no tick needed.
REQ-023 GAP: after GAP_TICKS ticks go PLAY_ON; simon_turn=1, simon_pressed=0.
REQ-024 PLAY_ON: simon_num=mem[index], simon_pressed=1 for ON_TICKS ticks; then index+1; if index+1<level -> GAP, else index=0, go WAIT_PRESS.
REQ-025 WAIT_PRESS: simon_turn=0; a rising edge of btn_pressed (versus previous cycle) SHALL compare btn_num with mem[index].
REQ-026 Match -> WAIT_RELEASE; mismatch -> OVER in the next cycle.
REQ-027 WAIT_RELEASE: on btn_pressed=0, index+1; if index+1<level -> WAIT_PRESS; else if level=MAX_LEN -> WIN; else APPEND.
REQ-028 btn_pressed already high on entry to WAIT_PRESS SHALL NOT count as a press; a new rising edge is required.
REQ-029 OVER/WIN: hold level; start=1 -> behave as IDLE start (restart directly).
REQ-030 start outside IDLE/OVER/WIN SHALL be ignored.
REQ-031 Tick counters SHALL reset to 0 on every state entry; tick coincident with a state change is not counted in the new state.
REQ-032 rnd >= NUM_CH (non-power-of-2 NUM_CH) SHALL be reduced mod NUM_CH.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, level=0, index=0, counters=0, simon_turn=0, simon_num=0, simon_pressed=0, game_over=0, win=0.
REQ-035 Reset mid-playback or mid-press SHALL discard the sequence; memory contents need not be cleared.

Configuration
REQ-036 Macro SIMON_TIMEOUT_EN defined: WAIT_PRESS with no rising edge for TIMEOUT_TICKS ticks SHALL go OVER; counter restarts on each WAIT_PRESS entry.
REQ-037 SIMON_TIMEOUT_EN undefined: WAIT_PRESS waits indefinitely; TIMEOUT_TICKS unused.

Verification
REQ-038 Reset, start=1 with rnd=2 -> level=1; after 10 ticks simon_num=2, simon_pressed=1 for 25 ticks, then simon_turn=0.
REQ-039 Rounds rnd=2 then 1; player presses 2, 1 correctly -> level=3 and playback of 2,1,x.
REQ-040 Round 1 sequence 2, player presses 3 -> game_over=1 next cycle, level=1; start=1 -> level=1 new game, game_over=0.
REQ-041 MAX_LEN=2, all presses correct -> win=1 after second release, level=2.
REQ-042 SIMON_TIMEOUT_EN defined, no press -> game_over=1 exactly after 250 ticks in WAIT_PRESS; undefined -> still WAIT_PRESS after 1000 ticks.
REQ-043 Reset asserted during PLAY_ON -> simon_pressed=0, simon_turn=0, level=0 without a clk edge.
